// File: rtl/sipo_pkg.sv
// sipo_pkg: shared types and constants for the serial_to_parallel block.
//   sipo_state_t    : receiver FSM states (IDLE, SHIFT, FULL)
//   SIPO_N          : default word width
//   sipo_cnt_width  : width needed for a counter reaching max_count
package sipo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } sipo_state_t;

  localparam int SIPO_N = 16;

  // Bits needed to hold values 0..max_count.
  function automatic int sipo_cnt_width(input int max_count);
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/sipo_bit_counter.sv
// sipo_bit_counter: accepted-bit counter for serial_to_parallel.
// Ports:
//   clk   : clock, rising edge
//   clr   : synchronous active-high reset (count -> 0)
//   clear : synchronous clear; combined with inc the count restarts at 1
//   inc   : count one accepted bit
//   cnt   : current count
//   tc    : cnt equals LAST, i.e. the bit accepted now completes the word
module sipo_bit_counter #(
  parameter int W    = 5,
  parameter int LAST = 15
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         tc
);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (clear) begin
      // Release-and-accept in one cycle: the new bit is bit 0 of the next word.
      cnt <= inc ? W'(1) : '0;
    end else if (inc) begin
      cnt <= cnt + W'(1);
    end
  end

  assign tc = (cnt == W'(LAST));

endmodule

// File: rtl/serial_to_parallel.sv
// serial_to_parallel: serial-in, parallel-out word assembler with a
// ready/valid handshake on the parallel side.
// Bit k of a word (k=0 first) lands at out[N-1-k], matching the word loaded
// into a right-shifting transmitter.
// Optional feature macro: SIPO_PARITY_EN -- each word carries one trailing
// even-parity bit that is checked (parity_err) but not stored in out.
// Ports:
//   clk        : clock, rising edge
//   clr        : synchronous active-high reset, overrides all inputs
//   sin        : serial data bit
//   sin_valid  : sin is sampled this cycle
//   out_ready  : consumer accepts the word held in FULL
//   out        : assembled word (registered)
//   out_valid  : out holds a complete word (state FULL)
//   busy       : a word is partially received (state SHIFT)
//   overrun    : sticky, a bit arrived while FULL and was dropped
//   parity_err : parity mismatch on the held word (0 without SIPO_PARITY_EN)
module serial_to_parallel
  import sipo_pkg::*;
#(
  parameter int N = SIPO_N
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         sin,
  input  logic         sin_valid,
  input  logic         out_ready,
  output logic [0:N-1] out,
  output logic         out_valid,
  output logic         busy,
  output logic         overrun,
  output logic         parity_err
);

`ifdef SIPO_PARITY_EN
  localparam int WORD_BITS = N + 1;
`else
  localparam int WORD_BITS = N;
`endif
  localparam int CW = sipo_cnt_width(WORD_BITS);

  sipo_state_t  state, state_next;
  logic [0:N-1] shreg, shreg_next, out_reg;
  logic [CW-1:0] cnt;
  logic          tc;
  logic          accept, shift_en, load_out, cnt_clear, set_ovr;

  sipo_bit_counter #(
    .W    (CW),
    .LAST (WORD_BITS - 1)
  ) u_cnt (
    .clk   (clk),
    .clr   (clr),
    .clear (cnt_clear),
    .inc   (accept),
    .cnt   (cnt),
    .tc    (tc)
  );

  // New bit enters index 0; older bits move toward index N-1.
  assign shreg_next = {sin, shreg[0:N-2]};

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    load_out   = 1'b0;
    cnt_clear  = 1'b0;
    set_ovr    = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (sin_valid) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (sin_valid) begin
          accept = 1'b1;
          if (tc) begin
            load_out   = 1'b1;
            state_next = FULL;
          end
        end
      end
      FULL: begin
        out_valid = 1'b1;
        if (out_ready) begin
          cnt_clear = 1'b1;
          if (sin_valid) begin
            accept     = 1'b1;
            state_next = SHIFT;
          end else begin
            state_next = IDLE;
          end
        end else if (sin_valid) begin
          set_ovr = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef SIPO_PARITY_EN
  // The completing bit is the parity bit; it is checked, never shifted in.
  assign shift_en = accept && !load_out;
`else
  assign shift_en = accept;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= IDLE;
      shreg   <= '0;
      out_reg <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_next;
      if (shift_en) begin
        shreg <= shreg_next;
      end
      if (load_out) begin
`ifdef SIPO_PARITY_EN
        out_reg <= shreg;
`else
        out_reg <= shreg_next;
`endif
      end
      if (set_ovr) begin
        overrun <= 1'b1;
      end
    end
  end

`ifdef SIPO_PARITY_EN
  logic perr_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      perr_q <= 1'b0;
    end else if (load_out) begin
      perr_q <= (^shreg) ^ sin;
    end
  end

  assign parity_err = out_valid && perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign out = out_reg;

endmodule

// File: tb/tb_serial_to_parallel.sv
// tb_serial_to_parallel: directed bench for serial_to_parallel (N=16).
// A word-level reference model (bit k of the word = k-th accepted bit)
// is checked against the DUT on every falling edge, and literal checks pin
// the expected values of the directed scenarios.
module tb_serial_to_parallel;

  localparam int N = 16;
`ifdef SIPO_PARITY_EN
  localparam int WB = N + 1;
`else
  localparam int WB = N;
`endif

  logic         clk = 1'b0;
  logic         clr, sin, sin_valid, out_ready;
  logic [0:N-1] out;
  logic         out_valid, busy, overrun, parity_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_to_parallel #(.N(N)) dut (
    .clk        (clk),
    .clr        (clr),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .out_ready  (out_ready),
    .out        (out),
    .out_valid  (out_valid),
    .busy       (busy),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collects accepted bits by index into a word value.
  int           m_cnt  = 0;
  logic [N-1:0] m_acc  = '0;
  logic [N-1:0] m_out  = '0;
  logic         m_par  = 1'b0;
  logic         m_full = 1'b0;
  logic         m_ovr  = 1'b0;
  logic         m_perr = 1'b0;

  task automatic model_accept(input logic b);
    if (m_cnt < N) m_acc[m_cnt] = b;
    else           m_par = b;
    m_cnt++;
    if (m_cnt == WB) begin
      m_full = 1'b1;
      m_out  = m_acc;
`ifdef SIPO_PARITY_EN
      m_perr = (^m_acc) ^ m_par;
`else
      m_perr = 1'b0;
`endif
    end
  endtask

  always @(posedge clk) begin
    if (clr) begin
      m_cnt = 0; m_acc = '0; m_out = '0; m_full = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
    end else if (m_full) begin
      if (out_ready) begin
        m_full = 1'b0;
        m_cnt  = 0;
        if (sin_valid) model_accept(sin);
      end else if (sin_valid) begin
        m_ovr = 1'b1;
      end
    end else if (sin_valid) begin
      model_accept(sin);
    end
  end

  always @(negedge clk) begin
    chk("out_valid", out_valid, m_full);
    chk("busy", busy, (m_cnt > 0) && !m_full);
    chk("overrun", overrun, m_ovr);
    chk("parity_err", parity_err, m_full && m_perr);
    if (m_full) chk("out", out, m_out);
  end

  // Apply inputs just after an edge; they are sampled at the next edge.
  task automatic cyc(input logic v, input logic s, input logic r, input logic c);
    sin_valid = v; sin = s; out_ready = r; clr = c;
    @(posedge clk);
    #1;
  endtask

  // Sends word w bit 0 first; rf = out_ready with the first bit, rr = with
  // the rest; gap inserts an idle cycle between bits.
  task automatic send_word(input logic [N-1:0] w, input logic rf, input logic rr, input logic gap);
    for (int k = 0; k < N; k++) begin
      cyc(1'b1, w[k], (k == 0) ? rf : rr, 1'b0);
      if (gap && k < N - 1) cyc(1'b0, 1'b0, rr, 1'b0);
      if (k == 0) chk("busy_after_bit0", busy, 1'b1);
    end
`ifdef SIPO_PARITY_EN
    cyc(1'b1, ^w, rr, 1'b0);
`endif
  endtask

  logic [N-1:0] pats [4] = '{16'h8001, 16'h7FFE, 16'h0F0F, 16'hC35A};

  initial begin
    clr = 1'b1; sin = 1'b0; sin_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    chk("rst_out", out, 16'h0000);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovr", overrun, 1'b0);

    // Continuous word, ready held high: valid one cycle after the last bit.
    send_word(16'hA5C3, 1'b1, 1'b1, 1'b0);
    chk("a5c3_valid", out_valid, 1'b1);
    chk("a5c3_out", out, 16'hA5C3);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("a5c3_released", out_valid, 1'b0);

    // Gapped word; stays FULL while ready is low.
    send_word(16'hA5C3, 1'b0, 1'b0, 1'b1);
    chk("gap_valid", out_valid, 1'b1);
    chk("gap_out", out, 16'hA5C3);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("gap_hold", out, 16'hA5C3);

    // Overrun: bit dropped, word kept, flag sticky past the handshake.
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("ovr_set", overrun, 1'b1);
    chk("ovr_out", out, 16'hA5C3);
    chk("ovr_busy", busy, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovr_sticky", overrun, 1'b1);
    chk("ovr_idle_valid", out_valid, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr_cleared", overrun, 1'b0);

    // Back-to-back: first bit of the second word arrives with the handshake.
    send_word(16'hFFFF, 1'b0, 1'b0, 1'b0);
    chk("b2b_first", out, 16'hFFFF);
    send_word(16'h0001, 1'b1, 1'b0, 1'b0);
    chk("b2b_second_valid", out_valid, 1'b1);
    chk("b2b_second", out, 16'h0001);
    chk("b2b_no_ovr", overrun, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);

    // Reset mid-word, then a fresh word.
    for (int k = 0; k < 7; k++) cyc(1'b1, k[0], 1'b0, 1'b0);
    chk("mid_busy", busy, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    chk("mid_rst_out", out, 16'h0000);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_valid", out_valid, 1'b0);
    send_word(16'h1234, 1'b0, 1'b0, 1'b0);
    chk("fresh_out", out, 16'h1234);
    // Reset while FULL.
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk("full_rst_valid", out_valid, 1'b0);
    chk("full_rst_out", out, 16'h0000);

    // Assorted patterns, model-checked, gapped on odd entries.
    for (int i = 0; i < 4; i++) begin
      send_word(pats[i], 1'b0, 1'b0, i[0]);
      chk("pat_valid", out_valid, 1'b1);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
    end

`ifdef SIPO_PARITY_EN
    for (int p = 0; p < 2; p++) begin
      logic [N-1:0] w3;
      w3 = 16'h0003;
      for (int k = 0; k < N; k++) cyc(1'b1, w3[k], 1'b0, 1'b0);
      cyc(1'b1, p[0], 1'b0, 1'b0);
      chk("par_out", out, 16'h0003);
      chk("par_err", parity_err, p[0]);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      chk("par_err_idle", parity_err, 1'b0);
    end
`endif

    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
